// File: rtl/div.sv
// Iterative radix-2 restoring divider, signed/unsigned, 33-cycle latency.
// Optional DIV_ZERO_FAST_EN: zero divisor completes the cycle after acceptance.
module div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_en,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             div_cancel,
    output logic             div_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_complete
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             accept;
    logic             last;
    logic             qbit;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] rem_nx, q_nx, q_fix, r_fix;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (div_en && !div_cancel) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = (div_src2 == '0) ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (div_cancel) state_d = IDLE;
                else if (last)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        div_ready    = (state_q == IDLE);
        div_complete = (state_q == DONE);
        quotient     = quo_q;
        remainder    = rmd_q;
    end

    // One restoring step; the trial carries two extra bits since an
    // unsigned divisor may use the full WIDTH range.
    always_comb begin
        accept  = (state_q == IDLE) && div_en && !div_cancel;
        last    = (cnt_q == CW'(WIDTH - 1));
        a_mag   = (signed_div && div_src1[WIDTH-1]) ? -div_src1 : div_src1;
        b_mag   = (signed_div && div_src2[WIDTH-1]) ? -div_src2 : div_src2;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dsr_q};
        qbit    = ~trial[WIDTH+1];
        rem_nx  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_nx    = {dvd_q[WIDTH-2:0], qbit};
        q_fix   = qneg_q ? -q_nx : q_nx;
        r_fix   = rneg_q ? -rem_nx : rem_nx;
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        src1_d = src1_q;
        quo_d  = quo_q;
        rmd_d  = rmd_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            cnt_d  = '0;
            rem_d  = '0;
            dvd_d  = a_mag;
            dsr_d  = b_mag;
            src1_d = div_src1;
            qneg_d = signed_div & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
            rneg_d = signed_div & div_src1[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
            if (div_src2 == '0) begin
                quo_d = '1;
                rmd_d = div_src1;
            end
`endif
        end else if (state_q == CALC && !div_cancel) begin
            cnt_d = cnt_q + CW'(1);
            rem_d = rem_nx;
            dvd_d = q_nx;
            if (last) begin
                quo_d = (dsr_q == '0) ? '1 : q_fix;
                rmd_d = (dsr_q == '0) ? src1_q : r_fix;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            src1_q <= '0;
            quo_q  <= '0;
            rmd_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            src1_q <= src1_d;
            quo_q  <= quo_d;
            rmd_q  <= rmd_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the iterative divider.
// Inputs change on negedge; outputs sampled on negedge.
module tb_div;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_en;
    logic        signed_div;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_cancel;
    logic        div_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_complete;

    int vectors = 0;
    int miscompares = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_en       (div_en),
        .signed_div   (signed_div),
        .div_src1     (div_src1),
        .div_src2     (div_src2),
        .div_cancel   (div_cancel),
        .div_ready    (div_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_complete (div_complete)
    );

    always #5 clk = ~clk;

    // Issue one op; lat = negedges from acceptance to pulse, 0 on timeout.
    task automatic run_op(input logic sg, input logic [31:0] a, b,
                          output int lat);
        @(negedge clk);
        signed_div = sg;
        div_src1   = a;
        div_src2   = b;
        div_en     = 1'b1;
        @(posedge clk);
        #1;
        div_en     = 1'b0;
        div_src1   = 32'hDEAD_BEEF;
        div_src2   = 32'h0000_0005;
        signed_div = ~sg;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (div_complete) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        div_en = 1'b0;
        signed_div = 1'b0;
        div_src1 = '0;
        div_src2 = '0;
        div_cancel = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (quotient !== 32'd0 || remainder !== 32'd0 ||
            div_complete !== 1'b0 || div_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: q=%h r=%h c=%b rdy=%b want 0 0 0 1",
                     quotient, remainder, div_complete, div_ready);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int lat;
        run_op(1'b0, 32'd100, 32'd7, lat);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("FAIL u100/7 latency: got %0d want 33", lat);
        end
        vectors++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            miscompares++;
            $display("FAIL u100/7: q=%h r=%h want e 2", quotient, remainder);
        end
        vectors++;
        if (div_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready in DONE: got %b want 0", div_ready);
        end
        @(negedge clk);
        vectors++;
        if (div_complete !== 1'b0 || div_ready !== 1'b1 ||
            quotient !== 32'd14 || remainder !== 32'd2) begin
            miscompares++;
            $display("FAIL pulse width/hold: c=%b rdy=%b q=%h r=%h want 0 1 e 2",
                     div_complete, div_ready, quotient, remainder);
        end
    endtask

    task automatic test_vectors;
        logic        sg[7];
        logic [31:0] a[7], b[7], q[7], r[7];
        int lat;
        sg[0]=1; a[0]=32'hFFFFFFF9; b[0]=32'd2;        q[0]=32'hFFFFFFFD; r[0]=32'hFFFFFFFF;
        sg[1]=1; a[1]=32'd7;        b[1]=32'hFFFFFFFE; q[1]=32'hFFFFFFFD; r[1]=32'd1;
        sg[2]=1; a[2]=32'hFFFFFFF9; b[2]=32'hFFFFFFFE; q[2]=32'd3;        r[2]=32'hFFFFFFFF;
        sg[3]=1; a[3]=32'h80000000; b[3]=32'hFFFFFFFF; q[3]=32'h80000000; r[3]=32'd0;
        sg[4]=0; a[4]=32'h80000000; b[4]=32'hFFFFFFFF; q[4]=32'd0;        r[4]=32'h80000000;
        sg[5]=0; a[5]=32'hFFFFFFFF; b[5]=32'hFFFFFFFF; q[5]=32'd1;        r[5]=32'd0;
        sg[6]=0; a[6]=32'hFFFFFFFF; b[6]=32'd2;        q[6]=32'h7FFFFFFF; r[6]=32'd1;
        for (int i = 0; i < 7; i++) begin
            run_op(sg[i], a[i], b[i], lat);
            vectors++;
            if (lat !== 33 || quotient !== q[i] || remainder !== r[i]) begin
                miscompares++;
                $display("FAIL vec%0d %h/%h s=%b: lat=%0d q=%h r=%h want 33 %h %h",
                         i, a[i], b[i], sg[i], lat, quotient, remainder, q[i], r[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        logic        sg[3];
        logic [31:0] a[3], r[3];
        int lat;
        sg[0]=1; a[0]=32'd7;        r[0]=32'd7;
        sg[1]=0; a[1]=32'd7;        r[1]=32'd7;
        sg[2]=1; a[2]=32'hFFFFFFF9; r[2]=32'hFFFFFFF9;
        for (int i = 0; i < 3; i++) begin
            run_op(sg[i], a[i], 32'd0, lat);
            vectors++;
            if (lat !== ZLAT || quotient !== 32'hFFFFFFFF || remainder !== r[i]) begin
                miscompares++;
                $display("FAIL divzero%0d: lat=%0d q=%h r=%h want %0d ffffffff %h",
                         i, lat, quotient, remainder, ZLAT, r[i]);
            end
            @(negedge clk);
            vectors++;
            if (div_complete !== 1'b0 || div_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL divzero%0d pulse: c=%b rdy=%b want 0 1",
                         i, div_complete, div_ready);
            end
        end
    endtask

    task automatic test_cancel;
        int lat;
        int seen;
        run_op(1'b0, 32'd100, 32'd7, lat);
        @(negedge clk);
        div_src1 = 32'd1000;
        div_src2 = 32'd3;
        signed_div = 1'b0;
        div_en = 1'b1;
        @(posedge clk);
        #1;
        div_en = 1'b0;
        repeat (10) @(negedge clk);
        div_cancel = 1'b1;
        @(posedge clk);
        #1;
        div_cancel = 1'b0;
        @(negedge clk);
        vectors++;
        if (div_ready !== 1'b1 || div_complete !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel idle: rdy=%b c=%b want 1 0", div_ready, div_complete);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_complete) seen++;
        end
        vectors++;
        if (seen !== 0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            miscompares++;
            $display("FAIL cancel hold: pulses=%0d q=%h r=%h want 0 e 2",
                     seen, quotient, remainder);
        end
        run_op(1'b0, 32'd9, 32'd3, lat);
        vectors++;
        if (lat !== 33 || quotient !== 32'd3 || remainder !== 32'd0) begin
            miscompares++;
            $display("FAIL after cancel 9/3: lat=%0d q=%h r=%h want 33 3 0",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        div_src1 = 32'd1000;
        div_src2 = 32'd3;
        signed_div = 1'b0;
        div_en = 1'b1;
        @(posedge clk);
        #1;
        div_en = 1'b0;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if (quotient !== 32'd0 || remainder !== 32'd0 ||
            div_complete !== 1'b0 || div_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset mid-op: q=%h r=%h c=%b rdy=%b want 0 0 0 1",
                     quotient, remainder, div_complete, div_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_complete) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset mid-op pulse: got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        div_src1 = 32'd20;
        div_src2 = 32'd6;
        signed_div = 1'b0;
        div_en = 1'b1;
        @(posedge clk);
        #1;
        div_src1 = 32'd100;
        div_src2 = 32'd7;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (div_complete) begin
                lat = i;
                break;
            end
        end
        vectors++;
        if (lat !== 33 || quotient !== 32'd3 || remainder !== 32'd2 ||
            div_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b first 20/6: lat=%0d q=%h r=%h rdy=%b want 33 3 2 0",
                     lat, quotient, remainder, div_ready);
        end
        @(negedge clk);
        vectors++;
        if (div_ready !== 1'b1 || div_complete !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b idle: rdy=%b c=%b want 1 0", div_ready, div_complete);
        end
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (div_complete) begin
                lat = i;
                break;
            end
        end
        div_en = 1'b0;
        vectors++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b second 100/7: lat=%0d q=%h r=%h want 33 e 2",
                     lat, quotient, remainder);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_vectors;
        test_div_zero;
        test_cancel;
        test_reset_mid;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
